// File: rtl/uart_loopback_fifo.sv
// UART loopback with RX/TX state machines, FIFO buffering and RTS/CTS.
// Bypass mode reproduces the plain wire loopback on both TX and FMC test pin.
module uart_loopback_fifo #(
  parameter int ClksPerBit   = 868,
  parameter int DataBits     = 8,
  parameter int FifoDepth    = 16,
  parameter int RtsThreshold = 12
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_uart_rx,
  output logic                             o_uart_tx,
  output logic                             o_uart_rts_n,
  input  logic                             i_uart_cts_n,
  input  logic                             i_bypass,
  output logic                             o_fmc_uart_test,
  output logic [$clog2(FifoDepth+1)-1:0]   o_fifo_count,
  output logic                             o_overflow,
  output logic                             o_frame_err,
  input  logic                             i_clr_err
);

  localparam int CW = $clog2(ClksPerBit);
  localparam int BW = $clog2(DataBits + 1);
  localparam int AW = $clog2(FifoDepth);
  localparam int NW = $clog2(FifoDepth + 1);

  localparam logic [CW-1:0] BitEnd  = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] HalfEnd = CW'(ClksPerBit / 2 - 1);
  localparam logic [BW-1:0] LastBit = BW'(DataBits - 1);
  localparam logic [NW-1:0] Full    = NW'(FifoDepth);
  localparam logic [NW-1:0] Thr     = NW'(RtsThreshold);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                rx_s1, rx_s;
  logic                cts_s1, cts_s;

  logic [1:0]          rx_st;
  logic [CW-1:0]       rx_cnt;
  logic [BW-1:0]       rx_idx;
  logic [DataBits-1:0] rx_sh;
  logic                rx_brk;
  logic                rx_push, rx_ferr;

  logic [1:0]          tx_st;
  logic [CW-1:0]       tx_cnt;
  logic [BW-1:0]       tx_idx;
  logic [DataBits-1:0] tx_sh;
  logic                tx_reg;
  logic                tx_end, tx_go, pop;

  logic [DataBits-1:0] mem [FifoDepth];
  logic [AW-1:0]       wptr, rptr;
  logic [NW-1:0]       count;
  logic                wr_ok, ovf_set;
  logic                ovf, ferr, rts_n;

  // Two-stage synchronisers for the asynchronous RX and CTS lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1  <= 1'b1;
      rx_s   <= 1'b1;
      cts_s1 <= 1'b1;
      cts_s  <= 1'b1;
    end else begin
      rx_s1  <= i_uart_rx;
      rx_s   <= rx_s1;
      cts_s1 <= i_uart_cts_n;
      cts_s  <= cts_s1;
    end
  end

  assign rx_push = (rx_st == S_STOP) && !rx_brk
                && (rx_cnt == BitEnd) && rx_s;
  assign rx_ferr = (rx_st == S_STOP) && !rx_brk
                && (rx_cnt == BitEnd) && !rx_s;

  // RX frame receiver; a bad stop bit parks in STOP until the line idles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
      rx_brk <= 1'b0;
    end else begin
      unique case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          rx_brk <= 1'b0;
          if (!rx_s) rx_st <= S_START;
        end
        S_START: begin
          if (rx_cnt == HalfEnd) begin
            rx_cnt <= '0;
            rx_st  <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[DataBits-1:1]};
            rx_idx <= rx_idx + BW'(1);
            if (rx_idx == LastBit) rx_st <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_brk) begin
            if (rx_s) rx_st <= S_IDLE;
          end else if (rx_cnt == BitEnd) begin
            rx_cnt <= '0;
            if (rx_s) rx_st <= S_IDLE;
            else      rx_brk <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign tx_end = (tx_cnt == BitEnd);
  assign tx_go  = (count != '0) && !cts_s;
  assign pop    = tx_go && ((tx_st == S_IDLE)
               || ((tx_st == S_STOP) && tx_end));

  // TX frame generator; chaining from STOP keeps frames back-to-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_reg <= 1'b1;
    end else if (pop) begin
      tx_st  <= S_START;
      tx_cnt <= '0;
      tx_sh  <= mem[rptr];
      tx_reg <= 1'b0;
    end else begin
      unique case (tx_st)
        S_IDLE: begin
          tx_cnt <= '0;
          tx_reg <= 1'b1;
        end
        S_START: begin
          if (tx_end) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_reg <= tx_sh[0];
            tx_st  <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_idx == LastBit) begin
              tx_reg <= 1'b1;
              tx_st  <= S_STOP;
            end else begin
              tx_reg <= tx_sh[1];
              tx_sh  <= tx_sh >> 1;
              tx_idx <= tx_idx + BW'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_end) begin
            tx_cnt <= '0;
            tx_st  <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign wr_ok   = rx_push && ((count != Full) || pop);
  assign ovf_set = rx_push && (count == Full) && !pop;

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr] <= rx_sh;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      unique case ({wr_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags and RTS; a set beats a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf   <= 1'b0;
      ferr  <= 1'b0;
      rts_n <= 1'b1;
    end else begin
      if (ovf_set)        ovf <= 1'b1;
      else if (i_clr_err) ovf <= 1'b0;
      if (rx_ferr)        ferr <= 1'b1;
      else if (i_clr_err) ferr <= 1'b0;
      rts_n <= (count >= Thr);
    end
  end

  assign o_uart_tx       = i_bypass ? i_uart_rx : tx_reg;
  assign o_fmc_uart_test = i_bypass ? i_uart_rx : tx_reg;
  assign o_uart_rts_n    = rts_n;
  assign o_fifo_count    = count;
  assign o_overflow      = ovf;
  assign o_frame_err     = ferr;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench for uart_loopback_fifo at 16 clocks per bit, depth 4.
// Each task drives one scenario and checks its own results inline.
module tb_uart_loopback_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       cts_n = 1'b1;
  logic       bypass = 1'b0;
  logic       clr = 1'b0;
  logic       tx, rts_n, fmc, ovf, ferr;
  logic [2:0] count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cnt_rise = 0;
  logic [2:0] prev_cnt = 3'd0;

  uart_loopback_fifo #(
    .ClksPerBit(16),
    .DataBits(8),
    .FifoDepth(4),
    .RtsThreshold(3)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_uart_rx(rx),
    .o_uart_tx(tx),
    .o_uart_rts_n(rts_n),
    .i_uart_cts_n(cts_n),
    .i_bypass(bypass),
    .o_fmc_uart_test(fmc),
    .o_fifo_count(count),
    .o_overflow(ovf),
    .o_frame_err(ferr),
    .i_clr_err(clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (prev_cnt == 3'd0 && count != 3'd0) cnt_rise <= cyc;
    prev_cnt <= count;
  end

  task automatic send_byte(input logic [7:0] d, input logic stp);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stp;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic get_frame(output logic [7:0] d, output logic s0,
                           output logic sp, output int t0,
                           output bit to);
    int n;
    n = 0;
    to = 1'b0;
    d = '0;
    s0 = 1'b1;
    sp = 1'b0;
    t0 = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      to = 1'b1;
      return;
    end
    t0 = cyc;
    repeat (8) @(negedge clk);
    s0 = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      d[i] = tx;
    end
    repeat (16) @(negedge clk);
    sp = tx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL reset_tx got=%b want=1", tx);
    end
    total++;
    if (fmc !== 1'b1) begin
      bad++; $display("FAIL reset_fmc got=%b want=1", fmc);
    end
    total++;
    if (rts_n !== 1'b1) begin
      bad++; $display("FAIL reset_rts got=%b want=1", rts_n);
    end
    total++;
    if (count !== 3'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if (ovf !== 1'b0 || ferr !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b want=00", ovf, ferr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (rts_n !== 1'b0) begin
      bad++; $display("FAIL reset_rts_rel got=%b want=0", rts_n);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic s0, sp;
    int t0;
    bit to;
    cts_n = 1'b0;
    repeat (4) @(negedge clk);
    fork
      send_byte(8'hA5, 1'b1);
      get_frame(d, s0, sp, t0, to);
    join
    total++;
    if (to) begin
      bad++; $display("FAIL single_timeout got=none want=frame");
    end
    total++;
    if (d !== 8'hA5) begin
      bad++; $display("FAIL single_data got=%h want=a5", d);
    end
    total++;
    if (s0 !== 1'b0 || sp !== 1'b1) begin
      bad++; $display("FAIL single_framing got=%b%b want=01", s0, sp);
    end
    total++;
    if (t0 - (cnt_rise - 1) > 2 || t0 < cnt_rise) begin
      bad++;
      $display("FAIL single_latency got=%0d want<=2",
               t0 - (cnt_rise - 1));
    end
    repeat (20) @(negedge clk);
    total++;
    if (count !== 3'd0) begin
      bad++; $display("FAIL single_count got=%0d want=0", count);
    end
  endtask

  task automatic test_flow_control();
    logic [7:0] d;
    logic s0, sp;
    int t0, prev_t;
    bit to;
    logic [2:0] ec;
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 1'b1);
      repeat (16) @(negedge clk);
      ec = (k > 4) ? 3'd4 : 3'(k);
      total++;
      if (count !== ec) begin
        bad++; $display("FAIL fc_count%0d got=%0d want=%0d", k, count, ec);
      end
      total++;
      if (rts_n !== (ec >= 3'd3)) begin
        bad++;
        $display("FAIL fc_rts%0d got=%b want=%b", k, rts_n, ec >= 3'd3);
      end
      total++;
      if (ovf !== (k == 5)) begin
        bad++; $display("FAIL fc_ovf%0d got=%b want=%b", k, ovf, k == 5);
      end
    end
    cts_n = 1'b0;
    prev_t = 0;
    for (int k = 1; k <= 4; k++) begin
      get_frame(d, s0, sp, t0, to);
      total++;
      if (to || d !== 8'(k) || s0 !== 1'b0 || sp !== 1'b1) begin
        bad++;
        $display("FAIL fc_frame%0d got=%h want=%h", k, d, 8'(k));
      end
      if (k > 1) begin
        total++;
        if (t0 - prev_t != 160) begin
          bad++;
          $display("FAIL fc_gap%0d got=%0d want=160", k, t0 - prev_t);
        end
      end
      if (k == 1) begin
        total++;
        if (count !== 3'd3 || rts_n !== 1'b1) begin
          bad++;
          $display("FAIL fc_drain1 got=%0d/%b want=3/1", count, rts_n);
        end
      end
      if (k == 2) begin
        total++;
        if (count !== 3'd2 || rts_n !== 1'b0) begin
          bad++;
          $display("FAIL fc_drain2 got=%0d/%b want=2/0", count, rts_n);
        end
      end
      prev_t = t0;
    end
    repeat (20) @(negedge clk);
    total++;
    if (count !== 3'd0 || tx !== 1'b1) begin
      bad++; $display("FAIL fc_empty got=%0d/%b want=0/1", count, tx);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL fc_clr got=%b want=0", ovf);
    end
  endtask

  task automatic test_frame_err();
    send_byte(8'h3C, 1'b0);
    repeat (16) @(negedge clk);
    total++;
    if (ferr !== 1'b1) begin
      bad++; $display("FAIL ferr_set got=%b want=1", ferr);
    end
    total++;
    if (count !== 3'd0 || tx !== 1'b1) begin
      bad++; $display("FAIL ferr_nopush got=%0d/%b want=0/1", count, tx);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (ferr !== 1'b0) begin
      bad++; $display("FAIL ferr_clr got=%b want=0", ferr);
    end
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (count != 3'd0 || tx !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL glitch_push got=activity want=none");
    end
    total++;
    if (ferr !== 1'b0) begin
      bad++; $display("FAIL glitch_err got=%b want=0", ferr);
    end
  endtask

  task automatic test_bypass();
    logic b;
    bypass = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom_range(0, 1));
      rx = b;
      #1;
      total++;
      if (tx !== b) begin
        bad++; $display("FAIL bypass_tx%0d got=%b want=%b", i, tx, b);
      end
      total++;
      if (fmc !== b) begin
        bad++; $display("FAIL bypass_fmc%0d got=%b want=%b", i, fmc, b);
      end
    end
    rx = 1'b1;
    bypass = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    bit seen;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    repeat (38) @(negedge clk);
    total++;
    if (tx !== 1'b0) begin
      bad++; $display("FAIL rst_midframe got=%b want=0", tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || count !== 3'd0) begin
      bad++; $display("FAIL rst_async got=%b/%0d want=1/0", tx, count);
    end
    total++;
    if (rts_n !== 1'b1) begin
      bad++; $display("FAIL rst_rts got=%b want=1", rts_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (rts_n !== 1'b1) begin
      bad++; $display("FAIL rst_rts_hold got=%b want=1", rts_n);
    end
    @(posedge clk);
    #1;
    total++;
    if (rts_n !== 1'b0) begin
      bad++; $display("FAIL rst_rts_edge got=%b want=0", rts_n);
    end
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || count != 3'd0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rst_discard got=activity want=idle");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flow_control();
    test_frame_err();
    test_glitch();
    test_bypass();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
